// File: rtl/pic_bus_master_if.sv
// Bundles the host request/response handshake and the 8259 bus pins.
// The master modport is the initiator side; the slave modport is the host/PIC side.
interface pic_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rd;
  logic       req_a0;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       a0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (
    input  req_valid, req_rd, req_a0, req_data, d_in,
    output req_ready, rsp_valid, rsp_data, cs_n, wr_n, rd_n, a0, d_out, d_oe
  );

  modport slave (
    output req_valid, req_rd, req_a0, req_data, d_in,
    input  req_ready, rsp_valid, rsp_data, cs_n, wr_n, rd_n, a0, d_out, d_oe
  );
endinterface

// File: rtl/pic_bus_master.sv
// 8259 bus initiator: runs setup/strobe/hold bus cycles for host requests
// and tracks the ICW1..ICW4 programming order of the writes it issues.
//
// state  | meaning
// IDLE   | cs_n high, req_ready high, waiting for a request
// SETUP  | cs_n low, a0/data valid ahead of the strobe
// STROBE | wr_n or rd_n low; read data captured on the last edge
// HOLD   | strobe released, cs_n/a0/data still held
module pic_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  pic_bus_master_if.master bus,
  output logic             init_done_o,
  output logic [2:0]       last_kind_o,
  output logic             seq_err_o
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  typedef enum logic [1:0] {OPER, EXP_ICW2, EXP_ICW3, EXP_ICW4} seq_e;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_e     state_q;
  seq_e       seq_q;
  logic [3:0] cnt_q;
  logic       rd_q;
  logic       ic4_q;
  logic       ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       cs_n_q;
  logic       wr_n_q;
  logic       rd_n_q;
  logic       a0_q;
  logic [7:0] d_out_q;
  logic       d_oe_q;
  logic       init_done_q;
  logic [2:0] last_kind_q;
  logic       seq_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      seq_q       <= OPER;
      cnt_q       <= 4'd0;
      rd_q        <= 1'b0;
      ic4_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      a0_q        <= 1'b0;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      init_done_q <= 1'b0;
      last_kind_q <= 3'd7;
      seq_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            rd_q    <= bus.req_rd;
            a0_q    <= bus.req_a0;
            cs_n_q  <= 1'b0;
            d_oe_q  <= !bus.req_rd;
            if (!bus.req_rd) d_out_q <= bus.req_data;
            cnt_q   <= SETUP_LD;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= STROBE_LD;
            state_q <= STROBE;
            if (rd_q) rd_n_q <= 1'b0;
            else      wr_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= HOLD_LD;
            state_q <= HOLD;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            if (rd_q) begin
              rsp_data_q  <= bus.d_in;
              rsp_valid_q <= 1'b1;
            end else if (!a0_q && d_out_q[4]) begin
              // ICW1 restarts the init sequence from any tracker state
              last_kind_q <= 3'd0;
              init_done_q <= 1'b0;
              ic4_q       <= d_out_q[0];
              seq_q       <= EXP_ICW2;
            end else if (seq_q == OPER) begin
              last_kind_q <= a0_q ? 3'd4 : (d_out_q[3] ? 3'd6 : 3'd5);
            end else if (!a0_q) begin
              seq_err_q <= 1'b1;
            end else begin
              case (seq_q)
                EXP_ICW2: begin
                  last_kind_q <= 3'd1;
                  seq_q       <= EXP_ICW3;
                end
                EXP_ICW3: begin
                  last_kind_q <= 3'd2;
                  if (ic4_q) begin
                    seq_q <= EXP_ICW4;
                  end else begin
                    seq_q       <= OPER;
                    init_done_q <= 1'b1;
                  end
                end
                default: begin
                  last_kind_q <= 3'd3;
                  seq_q       <= OPER;
                  init_done_q <= 1'b1;
                end
              endcase
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            d_oe_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.a0        = a0_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;
  assign init_done_o   = init_done_q;
  assign last_kind_o   = last_kind_q;
  assign seq_err_o     = seq_err_q;
endmodule

// File: tb/tb_pic_bus_master.sv
// Directed bench: default-timing instance driven from a vector table, plus a
// slow-timing instance used for reset-abort and long-cycle sequences.
module tb_pic_bus_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rd = 1'b0;
  logic       req_a0 = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] d_in = 8'h00;

  logic       init_done_a, init_done_b, seq_err_a, seq_err_b;
  logic [2:0] last_kind_a, last_kind_b;

  pic_bus_master_if if_a();
  pic_bus_master_if if_b();

  assign if_a.req_valid = req_valid & ~sel;
  assign if_a.req_rd    = req_rd;
  assign if_a.req_a0    = req_a0;
  assign if_a.req_data  = req_data;
  assign if_a.d_in      = d_in;
  assign if_b.req_valid = req_valid & sel;
  assign if_b.req_rd    = req_rd;
  assign if_b.req_a0    = req_a0;
  assign if_b.req_data  = req_data;
  assign if_b.d_in      = d_in;

  pic_bus_master dut_a (
    .clk(clk), .rst(rst), .bus(if_a.master),
    .init_done_o(init_done_a), .last_kind_o(last_kind_a), .seq_err_o(seq_err_a)
  );

  pic_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.master),
    .init_done_o(init_done_b), .last_kind_o(last_kind_b), .seq_err_o(seq_err_b)
  );

  always #5 clk = ~clk;

  logic       m_ready, m_rsp_valid, m_cs_n, m_wr_n, m_rd_n, m_d_oe, m_init_done, m_seq_err;
  logic [7:0] m_rsp_data;
  logic [2:0] m_last_kind;
  assign m_ready     = sel ? if_b.req_ready : if_a.req_ready;
  assign m_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign m_rsp_data  = sel ? if_b.rsp_data  : if_a.rsp_data;
  assign m_cs_n      = sel ? if_b.cs_n      : if_a.cs_n;
  assign m_wr_n      = sel ? if_b.wr_n      : if_a.wr_n;
  assign m_rd_n      = sel ? if_b.rd_n      : if_a.rd_n;
  assign m_d_oe      = sel ? if_b.d_oe      : if_a.d_oe;
  assign m_init_done = sel ? init_done_b    : init_done_a;
  assign m_seq_err   = sel ? seq_err_b      : seq_err_a;
  assign m_last_kind = sel ? last_kind_b    : last_kind_a;

  typedef struct {
    logic       rd;
    logic       a0;
    logic [7:0] data;
    logic [7:0] din;
    int         lk;
    int         id;
    int         err;
  } vec_t;

  vec_t vecs[17];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic run_txn(input logic rd, input logic a0v, input logic [7:0] data,
                         input logic [7:0] din, output int cs_lo, output int st_lo,
                         output int st_first, output int errs, output int rsps,
                         output int viol, output logic [7:0] rsp_cap, output int tmo);
    int   n;
    logic started;
    cs_lo = 0; st_lo = 0; st_first = -1; errs = 0; rsps = 0; viol = 0;
    rsp_cap = 8'h00; tmo = 0; started = 1'b0;
    @(negedge clk);
    req_rd = rd; req_a0 = a0v; req_data = data; d_in = din; req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) tmo = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (n < 60) begin
      if (!m_cs_n) begin
        started = 1'b1;
        if (!m_wr_n || !m_rd_n) begin
          if (st_first < 0) st_first = cs_lo;
          st_lo++;
        end
        cs_lo++;
        if (m_ready) viol++;
        if (rd ? m_d_oe : !m_d_oe) viol++;
        if (rd ? !m_wr_n : !m_rd_n) viol++;
      end else begin
        if (!m_wr_n || !m_rd_n) viol++;
        if (started) break;
      end
      if (m_rsp_valid) begin
        rsps++;
        rsp_cap = m_rsp_data;
      end
      if (m_seq_err) errs++;
      @(negedge clk);
      n++;
    end
    if (n >= 60) tmo = 1;
  endtask

  initial begin
    int cs_lo, st_lo, st_first, errs, rsps, viol, tmo, n;
    logic [7:0] rsp_cap;

    vecs[0]  = '{1'b0, 1'b0, 8'h13, 8'h00, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 8'h20, 8'h00, 1, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 2, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 8'h00, 3, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 8'h12, 8'h00, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 8'h08, 8'h00, 1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h00, 2, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 8'hFE, 8'h00, 4, 1, 0};
    vecs[8]  = '{1'b0, 1'b0, 8'h20, 8'h00, 5, 1, 0};
    vecs[9]  = '{1'b0, 1'b0, 8'h0B, 8'h00, 6, 1, 0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 8'hA5, 6, 1, 0};
    vecs[11] = '{1'b0, 1'b0, 8'h17, 8'h00, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 8'h20, 8'h00, 0, 0, 1};
    vecs[13] = '{1'b0, 1'b1, 8'h20, 8'h00, 1, 0, 0};
    vecs[14] = '{1'b1, 1'b1, 8'h00, 8'h3C, 1, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 8'h00, 2, 0, 0};
    vecs[16] = '{1'b0, 1'b1, 8'h05, 8'h00, 3, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(if_a.req_ready), 0);
    chk("rst_cs_n", int'(if_a.cs_n), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(if_a.req_ready), 1);
    chk("post_rst_bus", int'({if_a.cs_n, if_a.wr_n, if_a.rd_n, if_a.a0, if_a.d_oe}), 5'b11100);
    chk("post_rst_dout", int'(if_a.d_out), 0);
    chk("post_rst_rsp", int'({if_a.rsp_valid, if_a.rsp_data}), 0);
    chk("post_rst_last_kind", int'(last_kind_a), 7);
    chk("post_rst_init_seq", int'({init_done_a, seq_err_a}), 0);

    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i].rd, vecs[i].a0, vecs[i].data, vecs[i].din,
              cs_lo, st_lo, st_first, errs, rsps, viol, rsp_cap, tmo);
      chk($sformatf("v%0d_timeout", i), tmo, 0);
      chk($sformatf("v%0d_cs_low", i), cs_lo, 4);
      chk($sformatf("v%0d_strobe_low", i), st_lo, 2);
      chk($sformatf("v%0d_strobe_pos", i), st_first, 1);
      chk($sformatf("v%0d_bus_rules", i), viol, 0);
      chk($sformatf("v%0d_seq_err", i), errs, vecs[i].err);
      chk($sformatf("v%0d_rsp_pulses", i), rsps, int'(vecs[i].rd));
      if (vecs[i].rd) begin
        chk($sformatf("v%0d_rsp_cap", i), int'(rsp_cap), int'(vecs[i].din));
        chk($sformatf("v%0d_rsp_held", i), int'(m_rsp_data), int'(vecs[i].din));
      end
      chk($sformatf("v%0d_last_kind", i), int'(m_last_kind), vecs[i].lk);
      chk($sformatf("v%0d_init_done", i), int'(m_init_done), vecs[i].id);
      chk($sformatf("v%0d_ready_after", i), int'(m_ready), 1);
    end

    // Abort a write mid-strobe with rst; nothing of it may reach the tracker.
    @(negedge clk);
    req_rd = 1'b0; req_a0 = 1'b0; req_data = 8'h13; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (m_wr_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_strobe", int'(m_wr_n), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_bus", int'({m_cs_n, m_wr_n, m_rd_n, m_d_oe}), 4'b1110);
    chk("abort_init_done", int'(m_init_done), 0);
    chk("abort_last_kind", int'(m_last_kind), 7);
    chk("abort_seq_err", int'(m_seq_err), 0);
    chk("abort_ready", int'(m_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (m_rsp_valid || m_seq_err || !m_cs_n) errs++;
    end
    chk("abort_quiet", errs, 0);
    chk("abort_last_kind_after", int'(m_last_kind), 7);

    // Slow-timing instance: 3/4/2 gives a 9-cycle CS# window.
    sel = 1'b1;
    run_txn(1'b0, 1'b0, 8'h13, 8'h00, cs_lo, st_lo, st_first, errs, rsps, viol, rsp_cap, tmo);
    chk("slow_timeout", tmo, 0);
    chk("slow_cs_low", cs_lo, 9);
    chk("slow_strobe_low", st_lo, 4);
    chk("slow_strobe_pos", st_first, 3);
    chk("slow_bus_rules", viol, 0);
    chk("slow_last_kind", int'(m_last_kind), 0);
    run_txn(1'b1, 1'b1, 8'h00, 8'h5A, cs_lo, st_lo, st_first, errs, rsps, viol, rsp_cap, tmo);
    chk("slow_rd_timeout", tmo, 0);
    chk("slow_rd_cs_low", cs_lo, 9);
    chk("slow_rd_rsp", int'(rsp_cap), 8'h5A);
    chk("slow_rd_pulses", rsps, 1);
    chk("slow_rd_last_kind", int'(m_last_kind), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pic_bus_master.md
Name: pic_bus_master

Overview:
- CPU-side initiator for the 8259 PIC bus; the counterpart of the PIC's read/write decode logic.
- Turns single-word command requests from a host or sequencer into 8259 bus cycles: CS#, WR#/RD#, A0, D[7:0] with programmable setup/strobe/hold timing.
- Captures read data and mirrors the PIC's ICW1..ICW4 programming sequence, so the host sees init status and command classification.
- Sits between the system host logic and the PIC's external bus pins.

Parameters:
SETUP_CYC, 1, cycles CS#/A0/data are valid before the strobe falls (legal range 1..15)
STROBE_CYC, 2, cycles WR# or RD# is held low (legal range 1..15)
HOLD_CYC, 1, cycles CS#/A0/data are held after the strobe rises (legal range 1..15)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  host request valid
req_ready  out  1  master can accept a request
req_rd  in  1  1 = read cycle, 0 = write cycle
req_a0  in  1  A0 value for the cycle
req_data  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse: read data valid
rsp_data  out  8  captured read data, held until next read
cs_n  out  1  PIC chip select, active-low
wr_n  out  1  PIC write strobe, active-low
rd_n  out  1  PIC read strobe, active-low
a0  out  1  PIC A0
d_out  out  8  data driven toward PIC
d_oe  out  1  enable for the d_out tristate driver
d_in  in  8  data from PIC bus
init_done  out  1  ICW sequence completed since reset
last_kind  out  3  class of last completed write: 0..3 = ICW1..ICW4, 4 = OCW1, 5 = OCW2, 6 = OCW3, 7 = none
seq_err  out  1  one-cycle pulse: write violated the expected ICW order

Behaviour:
- Reset values: req_ready=0 during the rst cycle, then 1; cs_n=wr_n=rd_n=1; a0=0; d_out=0; d_oe=0; rsp_valid=0; rsp_data=0; init_done=0; last_kind=7; seq_err=0; FSM=IDLE; sequence state=OPER.
- All outputs are registered. Timing counter width is 4 bits.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: req_ready=1. A request is accepted on a clock edge where req_valid&&req_ready. The request fields are latched and the FSM enters SETUP.
- SETUP (SETUP_CYC cycles): cs_n=0, a0=latched value.
  - Write: d_out=data, d_oe=1.
  - Read: d_oe=0.
- STROBE (STROBE_CYC cycles): wr_n=0 (write) or rd_n=0 (read). cs_n, a0 and data are unchanged.
  - Read: d_in is sampled on the edge that ends the last STROBE cycle. rsp_data is updated on that edge and rsp_valid=1 for the first HOLD cycle only.
- HOLD (HOLD_CYC cycles): strobe is deasserted; cs_n, a0, d_out and d_oe are held. At the end of HOLD: cs_n=1, d_oe=0, return to IDLE.
- Cycle budget: a transaction occupies SETUP_CYC+STROBE_CYC+HOLD_CYC cycles with CS# low. At least one IDLE cycle (CS# high) separates back-to-back transactions. req_ready=0 outside IDLE.
- wr_n and rd_n are never low simultaneously. A strobe is never low while cs_n=1.
- Sequence tracker states: OPER, EXP_ICW2, EXP_ICW3, EXP_ICW4. The tracker updates on the edge where the write strobe rises (STROBE→HOLD); reads never affect it.
- Write classification:
  - A0=0 and data[4]=1 → ICW1, accepted from any state. Sets last_kind=0, clears init_done, latches IC4=data[0], goes to EXP_ICW2.
  - EXP_ICW2 with A0=1 → last_kind=1, go to EXP_ICW3.
  - EXP_ICW3 with A0=1 → last_kind=2. Go to EXP_ICW4 if IC4=1; else go to OPER and set init_done=1.
  - EXP_ICW4 with A0=1 → last_kind=3, go to OPER, init_done=1.
  - Any EXP_* state with A0=0 and data[4]=0 → seq_err pulses for one cycle; state and last_kind are unchanged. The write is still performed on the bus.
  - OPER with A0=1 → OCW1 (4).
  - OPER with A0=0, data[4]=0, data[3]=0 → OCW2 (5).
  - OPER with A0=0, data[4]=0, data[3]=1 → OCW3 (6).
  - OCW writes before any ICW1 are classified normally; init_done stays 0.
- req_valid in a non-IDLE state is ignored. The requester must hold the request until it is accepted.
- rst asserted mid-transaction: on that edge all strobes go high, cs_n=1, d_oe=0, and the FSM goes to IDLE. The in-flight request is dropped, with no rsp_valid and no tracker update. All other reset values apply.

Test Plan:
- Defaults (1/2/1), write A0=0 data=0x13 → cs_n low 4 cycles, wr_n low cycles 2–3 of that window, d_oe=1 throughout; last_kind=0; req_ready high again after cs_n rises.
- Sequence 0x13(A0=0), 0x20(A0=1), 0x00(A0=1), 0x01(A0=1) → last_kind 0,1,2,3; init_done=1 only after the 4th write.
- Sequence 0x12(A0=0, IC4=0), 0x08, 0x00 → init_done=1 after the 3rd write. Then A0=1 0xFE → last_kind=4; A0=0 0x20 → 5; A0=0 0x0B → 6.
- After ICW1, write A0=0 0x20 → seq_err single pulse; the next A0=1 write still yields last_kind=1.
- Read with d_in=0xA5 stable during the strobe → rsp_valid one cycle with rsp_data=0xA5; d_oe=0 for the whole cycle; tracker unchanged.
- rst asserted during STROBE of a write → the next cycle shows cs_n=wr_n=1, d_oe=0, init_done=0, last_kind=7, no seq_err; with SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2 a subsequent write keeps cs_n low 9 cycles with wr_n low 4.
